// File: rtl/nios2_cpu_debug_ocimem.sv
// On-chip debug monitor RAM: JTAG host reads/writes via the debug-slave pulses,
// plus a CPU Avalon-MM slave port on the same single-port RAM (JTAG has priority).
module nios2_cpu_debug_ocimem #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              jtag_busy,
    input  logic [ADDR_W-1:0] avalon_address,
    input  logic              avalon_read,
    input  logic              avalon_write,
    input  logic [31:0]       avalon_writedata,
    input  logic [3:0]        avalon_byteenable,
    input  logic              debugaccess,
    output logic [31:0]       avalon_readdata,
    output logic              avalon_waitrequest
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        J_RD = 2'd1,
        C_RD = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_pend;
    logic              r_pend_wr;
    logic [31:0]       r_mondreg;
    logic [ADDR_W-1:0] r_monareg;
    logic [31:0]       r_readdata;
    logic [31:0]       r_mem [2**ADDR_W];
    logic [31:0]       r_ram_q;

    logic              w_pulse;
    logic              w_jreq;
    logic              w_jsvc;
    logic              w_jsvc_wr;
    logic              w_wait;
    logic              w_ram_rd;
    logic              w_ram_we;
    logic [3:0]        w_ram_be;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [31:0]       w_ram_wdata;
    logic              w_unused;

    assign w_unused = ^{jdo[37:35], jdo[2:0]};

    // A pulse in flight counts as a JTAG request so the CPU cannot slip in ahead of it.
    assign w_pulse = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign w_jreq  = w_pulse | r_pend;

    always_comb begin
        w_state_nxt = r_state;
        w_jsvc      = 1'b0;
        w_jsvc_wr   = 1'b0;
        w_wait      = 1'b1;
        w_ram_rd    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_be    = '0;
        w_ram_addr  = avalon_address;
        w_ram_wdata = avalon_writedata;
        case (r_state)
            IDLE: begin
                if (!w_pulse && r_pend) begin
                    w_jsvc     = 1'b1;
                    w_ram_addr = r_monareg;
                    if (r_pend_wr) begin
                        w_jsvc_wr   = 1'b1;
                        w_ram_we    = 1'b1;
                        w_ram_be    = '1;
                        w_ram_wdata = r_mondreg;
                    end else begin
                        w_ram_rd    = 1'b1;
                        w_state_nxt = J_RD;
                    end
                end else if (!w_jreq && avalon_read) begin
                    w_ram_rd    = 1'b1;
                    w_state_nxt = C_RD;
                end else if (!w_jreq && avalon_write) begin
                    w_wait = 1'b0;
                    if (debugaccess) begin
                        w_ram_we = 1'b1;
                        w_ram_be = avalon_byteenable;
                    end
                end
            end
            J_RD: w_state_nxt = IDLE;
            C_RD: begin
                w_wait      = 1'b0;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (!reset_n) begin
            w_ram_rd = 1'b0;
            w_ram_we = 1'b0;
        end
    end

    assign avalon_waitrequest = w_wait | ~reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_pend     <= 1'b0;
            r_pend_wr  <= 1'b0;
            r_mondreg  <= '0;
            r_monareg  <= '0;
            r_readdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == J_RD)
                r_mondreg <= r_ram_q;
            if (r_state == C_RD)
                r_readdata <= r_ram_q;
            if (w_jsvc)
                r_pend <= 1'b0;
            if (w_jsvc_wr)
                r_monareg <= r_monareg + ADDR_W'(1);
            // Later assignments win: a new pulse replaces whatever was pending.
            if (take_action_ocimem_b) begin
                r_mondreg <= jdo[34:3];
                r_pend    <= 1'b1;
                r_pend_wr <= 1'b1;
            end else if (take_action_ocimem_a) begin
                r_monareg <= jdo[17 +: ADDR_W];
                r_pend    <= ~jdo[34];
                r_pend_wr <= 1'b0;
            end else if (take_no_action_ocimem_a) begin
                r_monareg <= r_monareg + ADDR_W'(1);
                r_pend    <= 1'b1;
                r_pend_wr <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (w_ram_be[b])
                    r_mem[w_ram_addr][8*b +: 8] <= w_ram_wdata[8*b +: 8];
            end
        end
        if (w_ram_rd)
            r_ram_q <= r_mem[w_ram_addr];
    end

    assign MonDReg         = r_mondreg;
    assign MonAReg         = r_monareg;
    assign avalon_readdata = r_readdata;
    assign jtag_busy       = r_pend | (r_state == J_RD);

endmodule

// File: tb/tb_nios2_cpu_debug_ocimem.sv
// Directed self-checking bench for the debug monitor RAM: JTAG reads/writes,
// address wrap, CPU byte writes, JTAG/CPU collision, command replacement, reset.
module tb_nios2_cpu_debug_ocimem;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_no_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic [31:0] MonDReg;
    logic [7:0]  MonAReg;
    logic        jtag_busy;
    logic [7:0]  avalon_address;
    logic        avalon_read;
    logic        avalon_write;
    logic [31:0] avalon_writedata;
    logic [3:0]  avalon_byteenable;
    logic        debugaccess;
    logic [31:0] avalon_readdata;
    logic        avalon_waitrequest;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    nios2_cpu_debug_ocimem #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .jtag_busy               (jtag_busy),
        .avalon_address          (avalon_address),
        .avalon_read             (avalon_read),
        .avalon_write            (avalon_write),
        .avalon_writedata        (avalon_writedata),
        .avalon_byteenable       (avalon_byteenable),
        .debugaccess             (debugaccess),
        .avalon_readdata         (avalon_readdata),
        .avalon_waitrequest      (avalon_waitrequest)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_jdo_a(input logic [7:0] addr, input logic rd);
        jdo        = '0;
        jdo[24:17] = addr;
        jdo[34]    = ~rd;
    endtask

    task automatic set_jdo_b(input logic [31:0] data);
        jdo       = '0;
        jdo[34:3] = data;
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] be, input logic dbg, output logic wr_wait);
        avalon_address    = addr;
        avalon_writedata  = data;
        avalon_byteenable = be;
        debugaccess       = dbg;
        avalon_write      = 1'b1;
        #1;
        wr_wait = avalon_waitrequest;
        step();
        avalon_write = 1'b0;
        debugaccess  = 1'b0;
    endtask

    // waits = number of stalled cycles before waitrequest dropped, -1 on timeout
    task automatic cpu_read(input logic [7:0] addr, output logic [31:0] data, output int waits);
        int n;
        avalon_address = addr;
        avalon_read    = 1'b1;
        waits = -1;
        data  = 'x;
        n     = 0;
        while (waits < 0 && n < 20) begin
            #1;
            if (avalon_waitrequest === 1'b0) begin
                waits = n;
                step();
                data = avalon_readdata;
            end else begin
                step();
            end
            n++;
        end
        avalon_read = 1'b0;
    endtask

    task automatic test_reset();
        avalon_write = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (MonDReg !== 32'h0) begin tests_failed++; $display("FAIL rst_mondreg: got %h expected %h", MonDReg, 32'h0); end
        tests_run++;
        if (MonAReg !== 8'h00) begin tests_failed++; $display("FAIL rst_monareg: got %h expected %h", MonAReg, 8'h00); end
        tests_run++;
        if (jtag_busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b expected 0", jtag_busy); end
        tests_run++;
        if (avalon_readdata !== 32'h0) begin tests_failed++; $display("FAIL rst_readdata: got %h expected %h", avalon_readdata, 32'h0); end
        tests_run++;
        if (avalon_waitrequest !== 1'b1) begin tests_failed++; $display("FAIL rst_wait: got %b expected 1", avalon_waitrequest); end
        avalon_write = 1'b0;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_addr_read();
        logic w;
        cpu_write(8'd5, 32'hDEADBEEF, 4'hF, 1'b1, w);
        tests_run++;
        if (w !== 1'b0) begin tests_failed++; $display("FAIL pre5_wait: got %b expected 0", w); end
        set_jdo_a(8'd5, 1'b1);
        take_action_ocimem_a = 1'b1;
        step();
        take_action_ocimem_a = 1'b0;
        tests_run++;
        if (MonAReg !== 8'h05) begin tests_failed++; $display("FAIL rd_monareg: got %h expected %h", MonAReg, 8'h05); end
        tests_run++;
        if (jtag_busy !== 1'b1) begin tests_failed++; $display("FAIL rd_busy1: got %b expected 1", jtag_busy); end
        tests_run++;
        if (MonDReg !== 32'h0) begin tests_failed++; $display("FAIL rd_early: got %h expected %h", MonDReg, 32'h0); end
        step();
        tests_run++;
        if (jtag_busy !== 1'b1) begin tests_failed++; $display("FAIL rd_busy2: got %b expected 1", jtag_busy); end
        step();
        tests_run++;
        if (MonDReg !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL rd_data: got %h expected %h", MonDReg, 32'hDEADBEEF); end
        tests_run++;
        if (jtag_busy !== 1'b0) begin tests_failed++; $display("FAIL rd_busy_end: got %b expected 0", jtag_busy); end
    endtask

    task automatic test_write_wrap();
        logic        w;
        logic [31:0] d;
        int          waits;
        cpu_write(8'd1, 32'hCAFEF00D, 4'hF, 1'b1, w);
        set_jdo_a(8'hFF, 1'b0);
        take_action_ocimem_a = 1'b1;
        step();
        take_action_ocimem_a = 1'b0;
        tests_run++;
        if (MonAReg !== 8'hFF) begin tests_failed++; $display("FAIL ld_monareg: got %h expected %h", MonAReg, 8'hFF); end
        tests_run++;
        if (jtag_busy !== 1'b0) begin tests_failed++; $display("FAIL ld_busy: got %b expected 0", jtag_busy); end
        set_jdo_b(32'h12345678);
        take_action_ocimem_b = 1'b1;
        step();
        take_action_ocimem_b = 1'b0;
        tests_run++;
        if (MonDReg !== 32'h12345678) begin tests_failed++; $display("FAIL wr_mondreg: got %h expected %h", MonDReg, 32'h12345678); end
        tests_run++;
        if (jtag_busy !== 1'b1) begin tests_failed++; $display("FAIL wr_busy: got %b expected 1", jtag_busy); end
        step();
        tests_run++;
        if (MonAReg !== 8'h00) begin tests_failed++; $display("FAIL wr_wrap: got %h expected %h", MonAReg, 8'h00); end
        take_no_action_ocimem_a = 1'b1;
        step();
        take_no_action_ocimem_a = 1'b0;
        tests_run++;
        if (MonAReg !== 8'h01) begin tests_failed++; $display("FAIL na_monareg: got %h expected %h", MonAReg, 8'h01); end
        step();
        step();
        tests_run++;
        if (MonDReg !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL na_data: got %h expected %h", MonDReg, 32'hCAFEF00D); end
        cpu_read(8'hFF, d, waits);
        tests_run++;
        if (d !== 32'h12345678) begin tests_failed++; $display("FAIL wr_ram_ff: got %h expected %h", d, 32'h12345678); end
        tests_run++;
        if (waits !== 1) begin tests_failed++; $display("FAIL rd_ff_waits: got %0d expected 1", waits); end
    endtask

    task automatic test_cpu_byte_write();
        logic        w;
        logic [31:0] d;
        int          waits;
        cpu_write(8'd3, 32'h0, 4'hF, 1'b1, w);
        cpu_write(8'd3, 32'hAABBCCDD, 4'b0101, 1'b1, w);
        tests_run++;
        if (w !== 1'b0) begin tests_failed++; $display("FAIL bw_wait: got %b expected 0", w); end
        cpu_read(8'd3, d, waits);
        tests_run++;
        if (d !== 32'h00BB00DD) begin tests_failed++; $display("FAIL bw_data: got %h expected %h", d, 32'h00BB00DD); end
        cpu_write(8'd3, 32'h11223344, 4'hF, 1'b0, w);
        tests_run++;
        if (w !== 1'b0) begin tests_failed++; $display("FAIL nodbg_wait: got %b expected 0", w); end
        cpu_read(8'd3, d, waits);
        tests_run++;
        if (d !== 32'h00BB00DD) begin tests_failed++; $display("FAIL nodbg_data: got %h expected %h", d, 32'h00BB00DD); end
    endtask

    task automatic test_collision();
        logic        w;
        logic [31:0] jd;
        int          n;
        int          waits;
        cpu_write(8'd7, 32'h77770007, 4'hF, 1'b1, w);
        cpu_write(8'd8, 32'h88880008, 4'hF, 1'b1, w);
        set_jdo_a(8'd8, 1'b1);
        take_action_ocimem_a = 1'b1;
        avalon_address = 8'd7;
        avalon_read    = 1'b1;
        waits = -1;
        jd    = 'x;
        n     = 0;
        while (waits < 0 && n < 20) begin
            #1;
            if (avalon_waitrequest === 1'b0) waits = n;
            step();
            take_action_ocimem_a = 1'b0;
            if (n == 2) jd = MonDReg;
            n++;
        end
        avalon_read = 1'b0;
        tests_run++;
        if (waits !== 4) begin tests_failed++; $display("FAIL col_waits: got %0d expected 4", waits); end
        tests_run++;
        if (avalon_readdata !== 32'h77770007) begin tests_failed++; $display("FAIL col_cpu_data: got %h expected %h", avalon_readdata, 32'h77770007); end
        tests_run++;
        if (jd !== 32'h88880008) begin tests_failed++; $display("FAIL col_jtag_data: got %h expected %h", jd, 32'h88880008); end
        tests_run++;
        if (MonDReg !== 32'h88880008) begin tests_failed++; $display("FAIL col_jtag_hold: got %h expected %h", MonDReg, 32'h88880008); end
    endtask

    task automatic test_replacement();
        logic w;
        cpu_write(8'd9,  32'h99990009, 4'hF, 1'b1, w);
        cpu_write(8'd10, 32'hAAAA000A, 4'hF, 1'b1, w);
        set_jdo_a(8'd9, 1'b1);
        take_action_ocimem_a = 1'b1;
        step();
        tests_run++;
        if (MonAReg !== 8'd9) begin tests_failed++; $display("FAIL rep_addr9: got %h expected %h", MonAReg, 8'd9); end
        set_jdo_a(8'd10, 1'b1);
        step();
        take_action_ocimem_a = 1'b0;
        tests_run++;
        if (MonAReg !== 8'd10) begin tests_failed++; $display("FAIL rep_addr10: got %h expected %h", MonAReg, 8'd10); end
        step();
        tests_run++;
        if (MonDReg !== 32'h88880008) begin tests_failed++; $display("FAIL rep_no9: got %h expected %h", MonDReg, 32'h88880008); end
        tests_run++;
        if (jtag_busy !== 1'b1) begin tests_failed++; $display("FAIL rep_busy: got %b expected 1", jtag_busy); end
        step();
        tests_run++;
        if (MonDReg !== 32'hAAAA000A) begin tests_failed++; $display("FAIL rep_data: got %h expected %h", MonDReg, 32'hAAAA000A); end
        tests_run++;
        if (jtag_busy !== 1'b0) begin tests_failed++; $display("FAIL rep_busy_end: got %b expected 0", jtag_busy); end
    endtask

    task automatic test_reset_mid_read();
        logic        w;
        logic [31:0] d;
        int          waits;
        cpu_write(8'd20, 32'h13572468, 4'hF, 1'b1, w);
        set_jdo_a(8'd20, 1'b1);
        take_action_ocimem_a = 1'b1;
        step();
        take_action_ocimem_a = 1'b0;
        step();
        tests_run++;
        if (jtag_busy !== 1'b1) begin tests_failed++; $display("FAIL mid_busy: got %b expected 1", jtag_busy); end
        reset_n           = 1'b0;
        avalon_address    = 8'd20;
        avalon_writedata  = 32'hFFFFFFFF;
        avalon_byteenable = 4'hF;
        debugaccess       = 1'b0;
        avalon_write      = 1'b1;
        #1;
        tests_run++;
        if (MonDReg !== 32'h0) begin tests_failed++; $display("FAIL mid_mondreg: got %h expected %h", MonDReg, 32'h0); end
        tests_run++;
        if (MonAReg !== 8'h00) begin tests_failed++; $display("FAIL mid_monareg: got %h expected %h", MonAReg, 8'h00); end
        tests_run++;
        if (jtag_busy !== 1'b0) begin tests_failed++; $display("FAIL mid_busy_rst: got %b expected 0", jtag_busy); end
        tests_run++;
        if (avalon_waitrequest !== 1'b1) begin tests_failed++; $display("FAIL mid_wait: got %b expected 1", avalon_waitrequest); end
        step();
        avalon_write = 1'b0;
        reset_n = 1'b1;
        step();
        tests_run++;
        if (MonDReg !== 32'h0) begin tests_failed++; $display("FAIL post_mondreg: got %h expected %h", MonDReg, 32'h0); end
        cpu_read(8'd20, d, waits);
        tests_run++;
        if (waits !== 1) begin tests_failed++; $display("FAIL post_waits: got %0d expected 1", waits); end
        tests_run++;
        if (d !== 32'h13572468) begin tests_failed++; $display("FAIL post_ram: got %h expected %h", d, 32'h13572468); end
    endtask

    initial begin
        reset_n                 = 1'b0;
        jdo                     = '0;
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
        avalon_address          = '0;
        avalon_read             = 1'b0;
        avalon_write            = 1'b0;
        avalon_writedata        = '0;
        avalon_byteenable       = '0;
        debugaccess             = 1'b0;
        test_reset();
        test_addr_read();
        test_write_wrap();
        test_cpu_byte_write();
        test_collision();
        test_replacement();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
